// File: rtl/command_pkg.sv
// Shared definitions for the ASCII command path: opcode bytes, ASCII ranges,
// decoder state encoding and the ASCII-hex to nibble mapping.
package command_pkg;

   localparam logic [7:0] OP_READ  = 8'h72;  // 'r'
   localparam logic [7:0] OP_WRITE = 8'h77;  // 'w'

   localparam logic [7:0] ASCII_0  = 8'h30;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_LA = 8'h61;  // 'a'
   localparam logic [7:0] ASCII_LF = 8'h66;  // 'f'
   localparam logic [7:0] ASCII_UA = 8'h41;  // 'A'
   localparam logic [7:0] ASCII_UF = 8'h46;  // 'F'
   localparam logic [7:0] ASCII_CR = 8'h0D;

   localparam int FIELD_DIGITS = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ADDR    = 3'd1,
      DATA    = 3'd2,
      EOL     = 3'd3,
      ISSUE   = 3'd4,
      DISCARD = 3'd5
   } state_t;

   // Returns {valid, nibble}; inverse of the response coder's nibble_to_ascii.
   function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c, input logic accept_upper);
      logic [4:0] r;
      r = 5'd0;
      if (c >= ASCII_0 && c <= ASCII_9)
         r = {1'b1, c[3:0]};
      else if (c >= ASCII_LA && c <= ASCII_LF)
         r = {1'b1, c[3:0] + 4'd9};
      else if (accept_upper && c >= ASCII_UA && c <= ASCII_UF)
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

endpackage

// File: rtl/hex_char_decoder.sv
// Combinational ASCII hex digit decoder; zero latency, no flow control.
// Wraps ascii_to_nibble so the mapping can be exercised on its own.
module hex_char_decoder
   import command_pkg::*;
#(
   parameter bit ACCEPT_UPPER = 1'b1
) (
   input  logic [7:0] i_char,
   output logic       o_valid,
   output logic [3:0] o_nibble
);

   assign {o_valid, o_nibble} = ascii_to_nibble(i_char, ACCEPT_UPPER);

endmodule

// File: rtl/command_ascii_decoder.sv
// Parses 'r'/'w' ASCII hex line commands into one held bus request per line.
// Request rises the cycle after EOL is accepted; tready is low only while a request awaits ack.
module command_ascii_decoder
   import command_pkg::*;
#(
   parameter bit         ACCEPT_UPPER = 1'b1,
   parameter logic [7:0] EOL_CHAR     = 8'h0A,
   parameter bit         IGNORE_CR    = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tvalid,
   input  logic [7:0]  tdata,
   output logic        tready,
   output logic        req,
   output logic        we,
   output logic [31:0] addr,
   output logic [31:0] wdata,
   input  logic        ack,
   output logic        err
);

   state_t      r_state;
   state_t      w_next;
   logic        r_rdy_en;
   logic [2:0]  r_cnt;
   logic        r_we;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic        r_err;

   logic        w_accept;
   logic        w_dig_vld;
   logic [3:0]  w_nib;
   logic        w_is_eol;
   logic        w_is_op;
   logic        w_drop_cr;
   logic        w_last_dig;
   logic        w_err_set;
   logic        w_tready;
   logic        w_req;

   hex_char_decoder #(
      .ACCEPT_UPPER (ACCEPT_UPPER)
   ) u_hex (
      .i_char   (tdata),
      .o_valid  (w_dig_vld),
      .o_nibble (w_nib)
   );

   assign w_accept   = tvalid & w_tready;
   assign w_is_eol   = (tdata == EOL_CHAR);
   assign w_is_op    = (tdata == OP_READ) || (tdata == OP_WRITE);
   assign w_drop_cr  = (IGNORE_CR != 1'b0) && (tdata == ASCII_CR);
   assign w_last_dig = (r_cnt == 3'(FIELD_DIGITS - 1));

   // r_rdy_en keeps tready low through reset and rises on the first cycle after it.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= IDLE;
         r_rdy_en <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_rdy_en <= 1'b1;
      end
   end

   always_comb begin
      w_next    = r_state;
      w_err_set = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (w_is_op) begin
                  w_next = ADDR;
               end else if (!w_is_eol && !w_drop_cr) begin
                  w_err_set = 1'b1;
                  w_next    = DISCARD;
               end
            end
         end
         ADDR, DATA: begin
            if (w_accept) begin
               if (w_dig_vld) begin
                  if (w_last_dig)
                     w_next = (r_state == ADDR && r_we) ? DATA : EOL;
               end else if (w_is_eol) begin
                  // Short field: the line is already over, so no discard needed.
                  w_err_set = 1'b1;
                  w_next    = IDLE;
               end else if (!w_drop_cr) begin
                  w_err_set = 1'b1;
                  w_next    = DISCARD;
               end
            end
         end
         EOL: begin
            if (w_accept) begin
               if (w_is_eol) begin
                  w_next = ISSUE;
               end else if (!w_drop_cr) begin
                  w_err_set = 1'b1;
                  w_next    = DISCARD;
               end
            end
         end
         ISSUE: begin
            if (ack)
               w_next = IDLE;
         end
         DISCARD: begin
            if (w_accept && w_is_eol)
               w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      w_tready = r_rdy_en && (r_state != ISSUE);
      w_req    = (r_state == ISSUE);
   end

   // Nothing is accepted in ISSUE, so we/addr/wdata stay frozen while req is high.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt   <= 3'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_err <= w_err_set;
         if (w_accept) begin
            case (r_state)
               IDLE: begin
                  if (w_is_op) begin
                     r_we   <= (tdata == OP_WRITE);
                     r_addr <= 32'd0;
                     r_cnt  <= 3'd0;
                  end
               end
               ADDR: begin
                  if (w_dig_vld) begin
                     r_addr <= {r_addr[27:0], w_nib};
                     r_cnt  <= r_cnt + 3'd1;
                     if (w_last_dig && r_we)
                        r_wdata <= 32'd0;
                  end
               end
               DATA: begin
                  if (w_dig_vld) begin
                     r_wdata <= {r_wdata[27:0], w_nib};
                     r_cnt   <= r_cnt + 3'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign tready = w_tready;
   assign req    = w_req;
   assign we     = r_we;
   assign addr   = r_addr;
   assign wdata  = r_wdata;
   assign err    = r_err;

endmodule

// File: tb/tb_command_ascii_decoder.sv
// Bench for command_ascii_decoder: table vectors, hand-built corner sequences and a
// randomized line stream scored against a line-level model.
module tb_command_ascii_decoder;

   logic        clk = 1'b0;
   logic        reset;
   logic        tvalid [2];
   logic [7:0]  tdata  [2];
   logic        tready [2];
   logic        req    [2];
   logic        we     [2];
   logic [31:0] addr   [2];
   logic [31:0] wdata  [2];
   logic        ack    [2];
   logic        err    [2];

   always #5 clk = ~clk;

   // Instance 0 accepts upper-case hex, instance 1 does not.
   command_ascii_decoder #(.ACCEPT_UPPER(1'b1), .EOL_CHAR(8'h0A), .IGNORE_CR(1'b1)) u_dut (
      .clk(clk), .reset(reset), .tvalid(tvalid[0]), .tdata(tdata[0]), .tready(tready[0]),
      .req(req[0]), .we(we[0]), .addr(addr[0]), .wdata(wdata[0]), .ack(ack[0]), .err(err[0]));

   command_ascii_decoder #(.ACCEPT_UPPER(1'b0), .EOL_CHAR(8'h0A), .IGNORE_CR(1'b1)) u_dut_lc (
      .clk(clk), .reset(reset), .tvalid(tvalid[1]), .tdata(tdata[1]), .tready(tready[1]),
      .req(req[1]), .we(we[1]), .addr(addr[1]), .wdata(wdata[1]), .ack(ack[1]), .err(err[1]));

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } req_t;

   typedef struct packed {
      int          inst;
      int          gap;
      int          dly;
      bit          tied;
      int          reqs;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          errs;
      int          len;
   } vec_t;

   int   checks   = 0;
   int   failures = 0;

   // Monitor / ack-responder state (written only by the negedge process).
   int   req_count [2] = '{0, 0};
   int   err_count [2] = '{0, 0};
   int   last_len  [2] = '{0, 0};
   int   viol      [2] = '{0, 0};
   int   age       [2] = '{0, 0};
   int   rnd_dly   [2] = '{0, 0};
   logic prev_req  [2] = '{1'b0, 1'b0};
   req_t cap       [2];
   req_t obs_q0 [$];
   req_t obs_q1 [$];

   // Ack configuration (written only by the stimulus process).
   int   ack_delay [2] = '{0, 0};
   bit   ack_idle  [2] = '{1'b0, 1'b0};
   bit   ack_rand  [2] = '{1'b0, 1'b0};

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            prev_req[i] = 1'b0;
            age[i]      = 0;
            ack[i]      = 1'b0;
         end else begin
            if (err[i]) err_count[i]++;
            if (req[i]) begin
               if (!prev_req[i]) begin
                  req_count[i]++;
                  last_len[i] = 1;
                  cap[i] = '{we: we[i], addr: addr[i], wdata: wdata[i]};
                  if (i == 0) obs_q0.push_back(cap[i]); else obs_q1.push_back(cap[i]);
                  rnd_dly[i] = $urandom_range(0, 3);
                  age[i] = 0;
               end else begin
                  last_len[i]++;
                  if (we[i] !== cap[i].we || addr[i] !== cap[i].addr ||
                      (cap[i].we && wdata[i] !== cap[i].wdata))
                     viol[i]++;
               end
               if (tready[i] !== 1'b0) viol[i]++;
               ack[i] = (age[i] >= (ack_rand[i] ? rnd_dly[i] : ack_delay[i]));
               age[i]++;
            end else begin
               ack[i] = ack_idle[i];
            end
            prev_req[i] = req[i];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic send_byte(input int i, input logic [7:0] b);
      int n;
      n = 0;
      tvalid[i] = 1'b1;
      tdata[i]  = b;
      while (tready[i] !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("tready_wait", 32'(n < 300), 32'd1);
      @(posedge clk);
      @(negedge clk);
      tvalid[i] = 1'b0;
   endtask

   task automatic wait_idle(input int i);
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (req[i] === 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("req_release", 32'(n < 300), 32'd1);
      @(negedge clk);
   endtask

   task automatic send_line(input int i, input string line, input int gap);
      for (int k = 0; k < line.len(); k++) begin
         if (gap > 0) begin
            tvalid[i] = 1'b0;
            repeat ($urandom_range(0, gap)) @(negedge clk);
         end
         send_byte(i, line[k]);
      end
      wait_idle(i);
   endtask

   task automatic check_outputs_zero(input string tag, input int i);
      chk({tag, "_tready"}, 32'(tready[i]), 32'd0);
      chk({tag, "_req"},    32'(req[i]),    32'd0);
      chk({tag, "_we"},     32'(we[i]),     32'd0);
      chk({tag, "_addr"},   addr[i],        32'd0);
      chk({tag, "_wdata"},  wdata[i],       32'd0);
      chk({tag, "_err"},    32'(err[i]),    32'd0);
   endtask

   // Reference model: whole-line classification. 0 = blank, 1 = request, 2 = one error.
   function automatic int hexval(input byte unsigned c, input bit up);
      if (c >= 48 && c <= 57)            return int'(c) - 48;
      if (c >= 97 && c <= 102)           return int'(c) - 87;
      if (up && c >= 65 && c <= 70)      return int'(c) - 55;
      return -1;
   endfunction

   function automatic int model_line(input string line, input bit up, output req_t r);
      string       t;
      logic [63:0] acc;
      int          h;
      byte unsigned c0;
      t   = "";
      acc = 64'd0;
      r   = '0;
      for (int k = 0; k < line.len(); k++)
         if (line[k] != 8'h0D && line[k] != 8'h0A) t = {t, line.substr(k, k)};
      if (t.len() == 0) return 0;
      c0 = t[0];
      if (!((c0 == 8'h72 && t.len() == 9) || (c0 == 8'h77 && t.len() == 17))) return 2;
      for (int k = 1; k < t.len(); k++) begin
         h = hexval(t[k], up);
         if (h < 0) return 2;
         acc = (acc << 4) | 64'(h);
      end
      r.we = (c0 == 8'h77);
      if (r.we) begin
         r.addr  = acc[63:32];
         r.wdata = acc[31:0];
      end else begin
         r.addr = acc[31:0];
      end
      return 1;
   endfunction

   function automatic string rand_hex();
      string hx;
      int    k;
      hx = "0123456789abcdefABCDEF";
      k  = $urandom_range(0, 21);
      return hx.substr(k, k);
   endfunction

   function automatic string gen_line();
      string s, t, bad;
      int    kind, nd, p;
      bad  = " gxZ:G";
      kind = $urandom_range(0, 5);
      if (kind == 4) return ($urandom_range(0, 1) == 1) ? "\r\n" : "\n";
      if (kind == 5) s = ($urandom_range(0, 1) == 1) ? "w" : "r";
      else           s = (kind < 2) ? "r" : "w";
      nd = (s == "r") ? 8 : 16;
      for (int j = 0; j < nd; j++) s = {s, rand_hex()};
      if (kind == 5) begin
         case ($urandom_range(0, 3))
            0: begin p = $urandom_range(1, s.len() - 1); s.putc(p, bad[$urandom_range(0, 5)]); end
            1: s = s.substr(0, $urandom_range(0, s.len() - 2));
            2: s = {s, rand_hex()};
            default: s.putc(0, bad[$urandom_range(0, 5)]);
         endcase
      end
      t = "";
      for (int k = 0; k < s.len(); k++) begin
         if ($urandom_range(0, 7) == 0) t = {t, "\r"};
         t = {t, s.substr(k, k)};
      end
      return {t, "\n"};
   endfunction

   task automatic run_random(input int i, input int nlines, input bit up);
      req_t  exp_q [$];
      req_t  r, o;
      string line;
      int    base, e0, exp_err, kind, nobs;
      base    = (i == 0) ? obs_q0.size() : obs_q1.size();
      e0      = err_count[i];
      exp_err = 0;
      ack_rand[i] = 1'b1;
      for (int n = 0; n < nlines; n++) begin
         line = gen_line();
         kind = model_line(line, up, r);
         if (kind == 1) exp_q.push_back(r);
         if (kind == 2) exp_err++;
         ack_idle[i] = 1'($urandom_range(0, 1));
         send_line(i, line, 2);
      end
      ack_rand[i] = 1'b0;
      ack_idle[i] = 1'b0;
      nobs = ((i == 0) ? obs_q0.size() : obs_q1.size()) - base;
      chk($sformatf("rand%0d_reqs", i), nobs, exp_q.size());
      chk($sformatf("rand%0d_errs", i), err_count[i] - e0, exp_err);
      for (int k = 0; k < exp_q.size() && k < nobs; k++) begin
         o = (i == 0) ? obs_q0[base + k] : obs_q1[base + k];
         chk($sformatf("rand%0d_we_%0d", i, k),   32'(o.we), 32'(exp_q[k].we));
         chk($sformatf("rand%0d_addr_%0d", i, k), o.addr,    exp_q[k].addr);
         if (exp_q[k].we)
            chk($sformatf("rand%0d_wdata_%0d", i, k), o.wdata, exp_q[k].wdata);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   vec_t  vecs   [11];
   string vlines [11];

   initial begin
      int r0, e0, v0, i;

      //             inst gap dly tied reqs we   addr          wdata         errs len
      vecs[0]  = '{0, 0, 3, 1'b0, 1, 1'b0, 32'h0000001C, 32'h0,        0, 4};
      vlines[0]  = "r0000001c\n";
      vecs[1]  = '{0, 0, 1, 1'b0, 1, 1'b1, 32'hDEADBEEF, 32'h12345678, 0, 2};
      vlines[1]  = "wDEADBEEF12345678\r\n";
      vecs[2]  = '{1, 0, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0,        1, 0};
      vlines[2]  = "wDEADBEEF12345678\r\n";
      vecs[3]  = '{1, 0, 0, 1'b0, 1, 1'b0, 32'h00000004, 32'h0,        0, 1};
      vlines[3]  = "r00000004\n";
      vecs[4]  = '{0, 0, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0,        1, 0};
      vlines[4]  = "r12g45678\n";
      vecs[5]  = '{0, 0, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0,        1, 0};
      vlines[5]  = "r123\n";
      vecs[6]  = '{0, 3, 0, 1'b1, 1, 1'b1, 32'h00000001, 32'h00000002, 0, 1};
      vlines[6]  = "w0000000100000002\n";
      vecs[7]  = '{0, 1, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0,        0, 0};
      vlines[7]  = "\r\n";
      vecs[8]  = '{0, 1, 0, 1'b0, 0, 1'b0, 32'h0,        32'h0,        1, 0};
      vlines[8]  = "q00000001\n";
      vecs[9]  = '{0, 1, 2, 1'b0, 0, 1'b0, 32'h0,        32'h0,        1, 0};
      vlines[9]  = "r00000001z\n";
      vecs[10] = '{0, 2, 0, 1'b1, 1, 1'b0, 32'h0000000A, 32'h0,        0, 1};
      vlines[10] = "r0\r000000A\n";

      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tvalid[k] = 1'b0;
         tdata[k]  = 8'h00;
      end
      repeat (3) @(negedge clk);
      check_outputs_zero("reset0", 0);
      check_outputs_zero("reset1", 1);
      reset = 1'b0;
      @(negedge clk);
      chk("tready_after_reset", 32'(tready[0]), 32'd1);

      for (int v = 0; v < 11; v++) begin
         i  = vecs[v].inst;
         ack_delay[i] = vecs[v].dly;
         ack_idle[i]  = vecs[v].tied;
         r0 = req_count[i];
         e0 = err_count[i];
         v0 = viol[i];
         send_line(i, vlines[v], vecs[v].gap);
         chk($sformatf("v%0d_reqs", v), req_count[i] - r0, vecs[v].reqs);
         chk($sformatf("v%0d_errs", v), err_count[i] - e0, vecs[v].errs);
         chk($sformatf("v%0d_hold", v), viol[i] - v0, 32'd0);
         if (vecs[v].reqs > 0) begin
            chk($sformatf("v%0d_we", v),   32'(cap[i].we), 32'(vecs[v].we));
            chk($sformatf("v%0d_addr", v), cap[i].addr,    vecs[v].addr);
            chk($sformatf("v%0d_len", v),  last_len[i],    vecs[v].len);
            if (vecs[v].we)
               chk($sformatf("v%0d_wdata", v), cap[i].wdata, vecs[v].wdata);
         end
         chk($sformatf("v%0d_tready_idle", v), 32'(tready[i]), 32'd1);
         ack_idle[i] = 1'b0;
      end

      // err is high exactly on the cycle after the offending byte.
      send_byte(0, "r");
      send_byte(0, "g");
      chk("err_pulse_digit", 32'(err[0]), 32'd1);
      @(negedge clk);
      chk("err_one_cycle", 32'(err[0]), 32'd0);
      send_byte(0, 8'h0A);
      chk("discard_no_err", 32'(err[0]), 32'd0);
      send_byte(0, "r");
      send_byte(0, "1");
      send_byte(0, 8'h0A);
      chk("err_pulse_short", 32'(err[0]), 32'd1);
      chk("short_back_idle", 32'(tready[0]), 32'd1);

      // Minimum latency: req one cycle after EOL acceptance.
      ack_delay[0] = 2;
      send_byte(0, "r");
      for (int k = 0; k < 7; k++) send_byte(0, "0");
      send_byte(0, "5");
      send_byte(0, 8'h0A);
      chk("lat_req", 32'(req[0]), 32'd1);
      chk("lat_tready", 32'(tready[0]), 32'd0);
      chk("lat_addr", addr[0], 32'h00000005);
      wait_idle(0);
      chk("lat_len", last_len[0], 32'd3);

      // Reset during the 5th address digit.
      send_byte(0, "r");
      for (int k = 0; k < 4; k++) send_byte(0, "7");
      tvalid[0] = 1'b1;
      tdata[0]  = "7";
      reset     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("rst_addr", 0);
      reset     = 1'b0;
      tvalid[0] = 1'b0;

      // Reset during ISSUE.
      ack_delay[0] = 20;
      send_byte(0, "w");
      for (int k = 0; k < 7; k++) send_byte(0, "0");
      send_byte(0, "1");
      for (int k = 0; k < 7; k++) send_byte(0, "0");
      send_byte(0, "2");
      send_byte(0, 8'h0A);
      chk("issue_req", 32'(req[0]), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outputs_zero("rst_issue", 0);
      reset = 1'b0;
      ack_delay[0] = 0;
      r0 = req_count[0];
      send_line(0, "r000000ff\n", 1);
      chk("post_rst_reqs", req_count[0] - r0, 32'd1);
      chk("post_rst_addr", cap[0].addr, 32'h000000FF);
      chk("post_rst_we", 32'(cap[0].we), 32'd0);

      v0 = viol[0];
      run_random(0, 30, 1'b1);
      run_random(1, 15, 1'b0);
      chk("rand_hold", viol[0] - v0, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
